// File: rtl/mux_nx1_stream.sv
// N-to-1 stream multiplexer with a single registered output stage.
// Channel `sel` is forwarded to a valid/ready output register; unselected
// channels never see ready. A drained register is refilled on the same edge,
// so back-to-back beats stream at one per cycle.
//
// Optional build macro: MUX_SEL_ERR_EN adds the sticky `sel_err` output, set
// when any in_valid is high while `sel` points past the last channel.
module mux_nx1_stream #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned N_IN  = 4,
  parameter int unsigned SEL_W = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [SEL_W-1:0]      sel,
  input  logic [N_IN*WIDTH-1:0] in_data,
  input  logic [N_IN-1:0]       in_valid,
  output logic [N_IN-1:0]       in_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_valid,
  input  logic                  out_ready
`ifdef MUX_SEL_ERR_EN
  ,
  output logic                  sel_err
`endif
);

  // One extra bit so N_IN == 2**SEL_W still fits in the comparison.
  localparam logic [SEL_W:0] NumIn = (SEL_W + 1)'(N_IN);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;

  logic             sel_ok;
  logic             load_en;
  logic             sel_valid;
  logic [WIDTH-1:0] sel_data;
  logic             transfer;

  // Unused select codes above N_IN-1 count as out of range.
  assign sel_ok  = ({1'b0, sel} < NumIn);
  // Register may load when empty or when its beat leaves this cycle.
  assign load_en = !out_valid_q || out_ready;

  // Pick the selected channel's valid and data; out-of-range leaves zeros.
  always_comb begin
    sel_valid = 1'b0;
    sel_data  = '0;
    for (int unsigned i = 0; i < N_IN; i++) begin
      if (sel == SEL_W'(i)) begin
        sel_valid = in_valid[i];
        sel_data  = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Ready goes only to the selected in-range channel, and never during reset.
  always_comb begin
    in_ready = '0;
    for (int unsigned i = 0; i < N_IN; i++) begin
      in_ready[i] = !rst && sel_ok && load_en && (sel == SEL_W'(i));
    end
  end

  assign transfer = sel_valid && sel_ok && load_en && !rst;

  // Output register next state: load on transfer, clear on drain, else hold.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (transfer) begin
      out_valid_d = 1'b1;
      out_data_d  = sel_data;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Output register with synchronous reset; a held beat is dropped on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

`ifdef MUX_SEL_ERR_EN
  logic sel_err_q, sel_err_d;

  // Sticky flag: any valid request while the select is out of range.
  always_comb begin
    sel_err_d = sel_err_q | (!sel_ok && (|in_valid));
  end

  // Flag register, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_err_q <= 1'b0;
    end else begin
      sel_err_q <= sel_err_d;
    end
  end

  assign sel_err = sel_err_q;
`endif

endmodule

// File: tb/tb_mux_nx1_stream.sv
// Testbench for mux_nx1_stream: a scoreboard-checked 4-channel instance plus a
// directed 3-channel instance exercising the unused select code.
module tb_mux_nx1_stream;

  logic       clk;
  logic       rst;

  // Main instance, WIDTH=8, N_IN=4, SEL_W=2.
  logic [1:0]  sel;
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;

  // Second instance, N_IN=3 so select code 3 is unused.
  logic [1:0]  sel3;
  logic [23:0] in_data3;
  logic [2:0]  in_valid3;
  logic [2:0]  in_ready3;
  logic [7:0]  out_data3;
  logic        out_valid3;
  logic        out_ready3;

`ifdef MUX_SEL_ERR_EN
  logic        sel_err;
  logic        sel_err3;
`endif

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic        mon_en   = 1'b0;

  logic [7:0]  sb_q[$];
  logic [7:0]  last_data = 8'h00;
  logic [3:0]  exp_rdy;

  mux_nx1_stream #(.WIDTH(8), .N_IN(4), .SEL_W(2)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .sel       (sel),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef MUX_SEL_ERR_EN
    ,
    .sel_err   (sel_err)
`endif
  );

  mux_nx1_stream #(.WIDTH(8), .N_IN(3), .SEL_W(2)) u_dut3 (
    .clk       (clk),
    .rst       (rst),
    .sel       (sel3),
    .in_data   (in_data3),
    .in_valid  (in_valid3),
    .in_ready  (in_ready3),
    .out_data  (out_data3),
    .out_valid (out_valid3),
    .out_ready (out_ready3)
`ifdef MUX_SEL_ERR_EN
    ,
    .sel_err   (sel_err3)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard for the main instance, sampled on the falling edge.
  always @(negedge clk) begin
    if (mon_en) begin
      int s;
      s = int'(sel);
      exp_rdy = 4'b0000;
      if (!rst && (sb_q.size() == 0 || out_ready)) exp_rdy[s] = 1'b1;
      check_eq("in_ready", 32'(in_ready), 32'(exp_rdy));
      check_eq("out_valid", 32'(out_valid), 32'(sb_q.size() != 0));
      check_eq("out_data", 32'(out_data), 32'((sb_q.size() != 0) ? sb_q[0] : last_data));
      // Predict the register contents after the coming edge.
      if (rst) begin
        sb_q.delete();
        last_data = 8'h00;
      end else begin
        if (sb_q.size() != 0 && out_ready) last_data = sb_q.pop_front();
        if (in_valid[s] && exp_rdy[s]) sb_q.push_back(in_data[s*8 +: 8]);
      end
    end
  end

  initial begin
    rst        = 1'b1;
    sel        = 2'd0;
    in_data    = 32'h0;
    in_valid   = 4'h0;
    out_ready  = 1'b0;
    sel3       = 2'd0;
    in_data3   = 24'h0;
    in_valid3  = 3'h0;
    out_ready3 = 1'b0;

    tick();
    mon_en = 1'b1;
    tick();
    rst = 1'b0;

    // Unused select code on the 3-channel instance.
    sel3 = 2'd3; in_valid3 = 3'b111; in_data3 = 24'h332211; out_ready3 = 1'b1;
    @(negedge clk);
    check_eq("n3_rdy_oor", 32'(in_ready3), 32'h0);
    check_eq("n3_vld_oor", 32'(out_valid3), 32'h0);
    tick();
    @(negedge clk);
    check_eq("n3_vld_oor2", 32'(out_valid3), 32'h0);
    check_eq("n3_dat_oor2", 32'(out_data3), 32'h0);
`ifdef MUX_SEL_ERR_EN
    check_eq("n3_sel_err", 32'(sel_err3), 32'h1);
`endif
    tick();
    sel3 = 2'd0; in_valid3 = 3'b000;
    tick();
    @(negedge clk);
`ifdef MUX_SEL_ERR_EN
    check_eq("n3_sel_err_sticky", 32'(sel_err3), 32'h1);
`endif
    in_valid3 = 3'b001; in_data3 = 24'h00005A;
    @(negedge clk);
    check_eq("n3_rdy_ch0", 32'(in_ready3), 32'h1);
    tick();
    sel3 = 2'd2; in_valid3 = 3'b100; in_data3 = 24'hC30000;
    @(negedge clk);
    check_eq("n3_vld_ch0", 32'(out_valid3), 32'h1);
    check_eq("n3_dat_ch0", 32'(out_data3), 32'h5A);
    check_eq("n3_rdy_ch2", 32'(in_ready3), 32'h4);
    tick();
    in_valid3 = 3'b000;
    @(negedge clk);
    check_eq("n3_dat_ch2", 32'(out_data3), 32'hC3);
    check_eq("n3_vld_ch2", 32'(out_valid3), 32'h1);
    tick();
    @(negedge clk);
    check_eq("n3_vld_drain", 32'(out_valid3), 32'h0);
    check_eq("n3_dat_hold", 32'(out_data3), 32'hC3);
    tick();

    // Basic accept of channel 2.
    sel = 2'd2; in_valid = 4'b0100; in_data = 32'h00A50000; out_ready = 1'b1;
    tick();
    in_valid = 4'b0000;
    tick();
    tick();

    // Backpressure: hold 3C while the select and channel-1 data wander.
    in_valid = 4'b0100; in_data = 32'h003C0000; out_ready = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      sel = 2'd1; in_valid = 4'b0010; in_data = 32'h00000040 + 32'(i << 8);
      tick();
    end
    out_ready = 1'b1; in_data = 32'h00007700;
    tick();
    in_valid = 4'b0000;
    tick();
    tick();

    // Streaming on channel 0, one beat per cycle.
    sel = 2'd0; in_valid = 4'b0001; out_ready = 1'b1;
    for (int d = 1; d <= 4; d++) begin
      in_data = 32'(d);
      tick();
    end
    in_valid = 4'b0000;
    tick();
    tick();

    // Reset while a beat is stalled in the register.
    sel = 2'd3; in_valid = 4'b1000; in_data = 32'h99000000; out_ready = 1'b0;
    tick();
    in_data = 32'h55000000;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    out_ready = 1'b1; in_valid = 4'b0000;
    tick();
    tick();

    // Random traffic with occasional resets.
    for (int i = 0; i < 300; i++) begin
      sel       = 2'($urandom_range(0, 3));
      in_valid  = 4'($urandom);
      in_data   = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      rst       = ($urandom_range(0, 39) == 0);
      tick();
    end
    rst = 1'b0; in_valid = 4'b0000; out_ready = 1'b1;
    tick();
    tick();
`ifdef MUX_SEL_ERR_EN
    @(negedge clk);
    check_eq("n4_sel_err_clear", 32'(sel_err), 32'h0);
`endif

    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
